// File: rtl/timer_pkg.sv
// ============================================================================
// Module : timer_pkg
// Brief  : Width helpers shared by the multi-channel millisecond timer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    // Bits needed to hold 0..max_val inclusive; never less than one bit.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed for a prescaler running 0..clks-1.
    function automatic int presc_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// ============================================================================
// Module : timer_channel
// Brief  : One up/down, one-shot/periodic timer slice stepped by a shared tick.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_channel
    import timer_pkg::*;
#(
    parameter int MAX_MS = 2047,
    parameter int W      = count_width(MAX_MS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         enable,
    input  logic         up,
    input  logic         periodic,
    input  logic         start,
    input  logic [W-1:0] limit_in,
    output logic [W-1:0] count,
    output logic         expired,
    output logic         done,
    output logic         expired_next
);

    localparam logic [W-1:0] C_MAX = W'(MAX_MS);

    logic [W-1:0] r_count_q, w_count_d;
    logic [W-1:0] r_limit_q, w_limit_d;
    logic         r_done_q,  w_done_d;
    logic         r_expired_q, w_expired_d;
    logic [W-1:0] w_clamped;
    logic         w_terminal;

    always_comb begin
        w_count_d   = r_count_q;
        w_limit_d   = r_limit_q;
        w_done_d    = r_done_q;
        w_expired_d = 1'b0;
        w_clamped   = (limit_in > C_MAX) ? C_MAX : limit_in;
        // An up-count sitting above the limit (limit or direction changed) is terminal.
        w_terminal  = up ? (r_count_q >= r_limit_q) : (r_count_q == '0);

        if (start) begin
            w_limit_d = w_clamped;
            w_count_d = up ? '0 : w_clamped;
            w_done_d  = 1'b0;
        end else if (tick && enable && !r_done_q) begin
            if (w_terminal) begin
                w_expired_d = 1'b1;
                if (periodic) begin
                    w_count_d = up ? '0 : r_limit_q;
                end else begin
                    w_done_d  = 1'b1;
                end
            end else begin
                w_count_d = up ? (r_count_q + 1'b1) : (r_count_q - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q   <= '0;
            r_limit_q   <= '0;
            r_done_q    <= 1'b0;
            r_expired_q <= 1'b0;
        end else begin
            r_count_q   <= w_count_d;
            r_limit_q   <= w_limit_d;
            r_done_q    <= w_done_d;
            r_expired_q <= w_expired_d;
        end
    end

    assign count        = r_count_q;
    assign expired      = r_expired_q;
    assign done         = r_done_q;
    assign expired_next = w_expired_d;

endmodule

`default_nettype wire

// File: rtl/multi_timer.sv
// ============================================================================
// Module : multi_timer
// Brief  : N-channel millisecond timer sharing one clock-cycle prescaler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_timer
    import timer_pkg::*;
#(
    parameter  int N_CH        = 2,
    parameter  int MAX_MS      = 2047,
    parameter  int CLKS_PER_MS = 50000,
    localparam int W           = count_width(MAX_MS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] enable,
    input  logic [N_CH-1:0] up,
    input  logic [N_CH-1:0] periodic,
    input  logic [N_CH-1:0] start,
    input  logic [N_CH*W-1:0] limit_in,
    output logic [N_CH*W-1:0] count,
    output logic [N_CH-1:0] expired,
    output logic [N_CH-1:0] done,
    output logic            expired_any
);

    localparam int             PW           = presc_width(CLKS_PER_MS);
    localparam logic [PW-1:0]  C_PRESC_LAST = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0]   r_presc_q, w_presc_d;
    logic            w_tick;
    logic            r_expired_any_q, w_expired_any_d;
    logic [N_CH-1:0] w_expired_next;

    always_comb begin
        w_tick          = (r_presc_q == C_PRESC_LAST);
        w_presc_d       = w_tick ? '0 : (r_presc_q + 1'b1);
        // Built from the channels' next-state so it lines up with the expired flops.
        w_expired_any_d = |w_expired_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_q       <= '0;
            r_expired_any_q <= 1'b0;
        end else begin
            r_presc_q       <= w_presc_d;
            r_expired_any_q <= w_expired_any_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .MAX_MS (MAX_MS),
            .W      (W)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .tick         (w_tick),
            .enable       (enable[i]),
            .up           (up[i]),
            .periodic     (periodic[i]),
            .start        (start[i]),
            .limit_in     (limit_in[i*W +: W]),
            .count        (count[i*W +: W]),
            .expired      (expired[i]),
            .done         (done[i]),
            .expired_next (w_expired_next[i])
        );
    end

    assign expired_any = r_expired_any_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_timer.sv
// ============================================================================
// Module : tb_multi_timer
// Brief  : Directed self-checking bench for multi_timer (2 ch, 4-bit, /4 tick).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] enable, up, periodic, start;
    logic [7:0] limit_in;
    logic [7:0] count;
    logic [1:0] expired, done;
    logic       expired_any;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    multi_timer #(
        .N_CH        (2),
        .MAX_MS      (15),
        .CLKS_PER_MS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .up          (up),
        .periodic    (periodic),
        .start       (start),
        .limit_in    (limit_in),
        .count       (count),
        .expired     (expired),
        .done        (done),
        .expired_any (expired_any)
    );

    always #5 clk = ~clk;

    // Bench-side tick phase: ph==3 at a negedge means the next posedge is a tick.
    always @(posedge clk) ph <= reset ? 0 : ((ph == 3) ? 0 : ph + 1);

    task automatic wait_tick();
        int g = 0;
        while (ph != 3 && g < 8) begin
            @(negedge clk);
            g++;
        end
        if (g >= 8) begin
            total++; bad++;
            $display("FAIL tick_timeout got=%0d want=3", ph);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = '0; up = '0; periodic = '0; start = '0; limit_in = '0;
        repeat (3) @(negedge clk);
        total++; if (count !== 8'h00) begin bad++; $display("FAIL rst_count got=%h want=00", count); end
        total++; if (done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b want=00", done); end
        total++; if (expired !== 2'b00 || expired_any !== 1'b0) begin bad++; $display("FAIL rst_expired got=%b/%b want=00/0", expired, expired_any); end
        reset = 1'b0; start = 2'b01; up = 2'b01; enable = 2'b01; limit_in = 8'h0F;
        @(negedge clk);
        start = '0;
        total++; if (count[3:0] !== 4'd0) begin bad++; $display("FAIL rst_load got=%0d want=0", count[3:0]); end
        repeat (2) @(negedge clk);
        total++; if (count[3:0] !== 4'd0) begin bad++; $display("FAIL rst_pre_tick got=%0d want=0", count[3:0]); end
        @(negedge clk);
        total++; if (count[3:0] !== 4'd1) begin bad++; $display("FAIL rst_first_tick got=%0d want=1", count[3:0]); end
        wait_tick();
        total++; if (count[3:0] !== 4'd2) begin bad++; $display("FAIL rst_second_tick got=%0d want=2", count[3:0]); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0; enable = '0;
        total++; if (count !== 8'h00 || done !== 2'b00 || expired !== 2'b00) begin bad++; $display("FAIL rst_mid got=%h/%b/%b want=00/00/00", count, done, expired); end
    endtask

    task automatic test_oneshot_up();
        start = 2'b01; up = 2'b01; periodic = 2'b00; enable = 2'b01; limit_in = 8'h03;
        @(negedge clk);
        start = '0;
        total++; if (count[3:0] !== 4'd0) begin bad++; $display("FAIL os_load got=%0d want=0", count[3:0]); end
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            total++; if (count[3:0] !== 4'(k) || expired[0] !== 1'b0) begin bad++; $display("FAIL os_count got=%0d/%b want=%0d/0", count[3:0], expired[0], k); end
        end
        wait_tick();
        total++; if (expired[0] !== 1'b1 || expired_any !== 1'b1) begin bad++; $display("FAIL os_expired got=%b/%b want=1/1", expired[0], expired_any); end
        total++; if (done[0] !== 1'b1 || count[3:0] !== 4'd3) begin bad++; $display("FAIL os_done got=%b/%0d want=1/3", done[0], count[3:0]); end
        @(negedge clk);
        total++; if (expired[0] !== 1'b0 || expired_any !== 1'b0) begin bad++; $display("FAIL os_pulse_width got=%b/%b want=0/0", expired[0], expired_any); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++; if (count[3:0] !== 4'd3 || done[0] !== 1'b1 || expired[0] !== 1'b0) begin bad++; $display("FAIL os_hold got=%0d/%b/%b want=3/1/0", count[3:0], done[0], expired[0]); end
        end
    endtask

    task automatic test_periodic_down();
        int ec[6] = '{1, 0, 2, 1, 0, 2};
        int ee[6] = '{0, 0, 1, 0, 0, 1};
        reset = 1'b1; enable = '0;
        @(negedge clk);
        reset = 1'b0; start = 2'b10; up = 2'b00; periodic = 2'b10; enable = 2'b10; limit_in = 8'h20;
        @(negedge clk);
        start = '0;
        total++; if (count[7:4] !== 4'd2) begin bad++; $display("FAIL pd_load got=%0d want=2", count[7:4]); end
        for (int k = 0; k < 6; k++) begin
            wait_tick();
            total++; if (count[7:4] !== 4'(ec[k]) || expired[1] !== ee[k][0]) begin bad++; $display("FAIL pd_step got=%0d/%b want=%0d/%0d", count[7:4], expired[1], ec[k], ee[k]); end
            total++; if (count[3:0] !== 4'd0 || expired[0] !== 1'b0) begin bad++; $display("FAIL pd_idle got=%0d/%b want=0/0", count[3:0], expired[0]); end
        end
    endtask

    task automatic test_full_range();
        enable = 2'b01; start = 2'b01; up = 2'b00; periodic = 2'b00; limit_in = 8'h0F;
        @(negedge clk);
        start = '0;
        total++; if (count[3:0] !== 4'd15) begin bad++; $display("FAIL fr_down_load got=%0d want=15", count[3:0]); end
        start = 2'b01; up = 2'b01;
        @(negedge clk);
        start = '0;
        total++; if (count[3:0] !== 4'd0) begin bad++; $display("FAIL fr_up_load got=%0d want=0", count[3:0]); end
        for (int k = 1; k <= 15; k++) begin
            wait_tick();
            total++; if (count[3:0] !== 4'(k)) begin bad++; $display("FAIL fr_count got=%0d want=%0d", count[3:0], k); end
        end
        wait_tick();
        total++; if (expired[0] !== 1'b1 || done[0] !== 1'b1 || count[3:0] !== 4'd15) begin bad++; $display("FAIL fr_terminal got=%b/%b/%0d want=1/1/15", expired[0], done[0], count[3:0]); end
    endtask

    task automatic test_start_on_tick();
        wait_tick();
        start = 2'b11; up = 2'b11; periodic = 2'b11; enable = 2'b11; limit_in = 8'hFA;
        @(negedge clk);
        start = '0;
        wait_tick();
        wait_tick();
        total++; if (count !== 8'h22) begin bad++; $display("FAIL st_run got=%h want=22", count); end
        repeat (3) @(negedge clk);
        start = 2'b01;
        @(negedge clk);
        start = '0;
        total++; if (count[3:0] !== 4'd0) begin bad++; $display("FAIL st_load_wins got=%0d want=0", count[3:0]); end
        total++; if (count[7:4] !== 4'd3) begin bad++; $display("FAIL st_other_ch got=%0d want=3", count[7:4]); end
        wait_tick();
        wait_tick();
        total++; if (count !== 8'h52) begin bad++; $display("FAIL st_after got=%h want=52", count); end
        enable = 2'b10;
        wait_tick();
        wait_tick();
        total++; if (count !== 8'h72) begin bad++; $display("FAIL en_frozen got=%h want=72", count); end
        enable = 2'b11;
        wait_tick();
        total++; if (count !== 8'h83) begin bad++; $display("FAIL en_resume got=%h want=83", count); end
    endtask

    task automatic test_limit_zero();
        start = 2'b11; up = 2'b01; periodic = 2'b11; enable = 2'b11; limit_in = 8'h00;
        @(negedge clk);
        start = '0;
        total++; if (count !== 8'h00) begin bad++; $display("FAIL lz_load got=%h want=00", count); end
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            total++; if (expired !== 2'b11 || expired_any !== 1'b1) begin bad++; $display("FAIL lz_expired got=%b/%b want=11/1", expired, expired_any); end
            total++; if (count !== 8'h00 || done !== 2'b00) begin bad++; $display("FAIL lz_count got=%h/%b want=00/00", count, done); end
            @(negedge clk);
            total++; if (expired !== 2'b00 || expired_any !== 1'b0) begin bad++; $display("FAIL lz_pulse got=%b/%b want=00/0", expired, expired_any); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot_up();
        test_periodic_down();
        test_full_range();
        test_start_on_tick();
        test_limit_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
